pdm_port_sink: RTL and testbench
================================

Name: pdm_port_sink

Overview:
- Downstream consumer of one PDM core output port (newdata_len_N / proceed_N / data_out_N); one instance per port, four in the full environment.
- Grants packet transfers with the proceed handshake, captures the payload bytes into an internal FIFO, and presents them to a byte-wide read interface.
- Oversized packets are drained and discarded. Error and packet counts are exported for scoreboard and coverage use.

Parameters:
- DATA_W, 8, width of data_out, FIFO entries and rd_data.
- DEPTH, 16, FIFO depth in bytes; must be a power of 2, minimum 4.
- LEN_W, 8, width of newdata_len.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- newdata_len  in  LEN_W  pending packet length from core; nonzero = request; core holds it until it sees proceed.
- proceed  out  1  one-cycle grant to core.
- data_out  in  DATA_W  payload byte from core; one per cycle after a grant.
- rd_en  in  1  pop one byte from FIFO.
- rd_data  out  DATA_W  popped byte, registered.
- rd_valid  out  1  rd_data valid; asserted the cycle after an accepted rd_en.
- empty  out  1  FIFO level == 0.
- level  out  $clog2(DEPTH)+1  FIFO occupancy in bytes.
- pkt_cnt  out  8  packets fully stored; wraps 255 -> 0.
- len_err  out  1  sticky; set when a packet with len > DEPTH was drained.

Behaviour:
- Reset values (registered, synchronous):
  - proceed=0, rd_data=0, rd_valid=0, level=0, empty=1, pkt_cnt=0, len_err=0.
  - FIFO pointers 0, FSM in IDLE, byte counter 0.
- FSM states: IDLE, GRANT, RECV, DROP.
- IDLE:
  - If newdata_len != 0 and newdata_len <= DEPTH - level: latch len, go to GRANT.
  - Else if newdata_len > DEPTH: latch len, go to GRANT with the drop flag set.
  - Else (len fits DEPTH but not current free space): stay in IDLE; no proceed.
- GRANT:
  - proceed=1 for exactly this cycle.
  - Next state is RECV, or DROP if the drop flag is set.
  - Byte counter loads len.
- RECV:
  - Each cycle, write data_out into the FIFO and decrement the counter.
  - On the cycle the counter reaches 0 (last byte written): pkt_cnt += 1, go to IDLE.
- DROP:
  - Same byte timing as RECV; bytes are discarded and the FIFO is unchanged.
  - On the last byte: set len_err, go to IDLE. pkt_cnt is not incremented.
- Timing: request seen at cycle T -> proceed at T+1 -> bytes captured at T+2 .. T+1+len. Earliest next proceed is T+3+len (IDLE occupies one cycle between packets).
- Free-space check uses the level at the decision cycle only; concurrent reads can only add space, so overflow is impossible.
- Read path:
  - rd_en with level > 0: rd_data <= head byte, rd_valid=1 the next cycle.
  - rd_en with level == 0: ignored; rd_valid=0 next cycle; no pointer or level change.
- Simultaneous FIFO write and accepted read: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Level: full = DEPTH, flagged via level only; empty = (level == 0).
- newdata_len is ignored outside IDLE.
- data_out is ignored in IDLE and GRANT.
- Reset asserted mid-packet: immediate return to reset values next edge. Residual bytes from the core are ignored because the FSM is in IDLE, and newdata_len == 0 is expected after a core reset.
- len_err clears only on reset.

Test Plan:
- Basic packet: reset, newdata_len=3, data_out 0xA1,0xA2,0xA3 after proceed -> proceed high 1 cycle at T+1; level=3; pkt_cnt=1; three rd_en pulses -> rd_data 0xA1,0xA2,0xA3 with rd_valid each following cycle; empty=1.
- Backpressure: fill 14 bytes (DEPTH=16), request len=4 -> no proceed; pop 2 bytes -> proceed asserted the cycle after level reaches 12; final level=16.
- Oversize: newdata_len=20 -> proceed, 20 bytes drained, level stays 0, len_err=1, pkt_cnt unchanged; subsequent len=2 packet is still accepted normally.
- Concurrent read/write: level=5, rd_en held during a 4-byte RECV -> level decrements/holds correctly, ending at 5; byte order preserved across pointer wrap (write pointer starts at 14).
- Reset mid-packet: assert reset after 2 of 6 bytes -> next cycle level=0, proceed=0, pkt_cnt=0; remaining 4 bytes not stored; new len=1 packet works.
- Empty read + counter wrap: rd_en while empty -> rd_valid=0, level=0; send 256 one-byte packets with draining -> pkt_cnt wraps to 0.

Source files
------------

// File: rtl/pdm_port_sink_if.sv
// Core-facing transfer handshake and byte-wide read port of one PDM output port sink.
interface pdm_port_sink_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LEN_W  = 8
) ();
    logic [LEN_W-1:0]       newdata_len;
    logic                   proceed;
    logic [DATA_W-1:0]      data_out;
    logic                   rd_en;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_valid;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;

    modport slave (
        input  newdata_len, data_out, rd_en,
        output proceed, rd_data, rd_valid, empty, level
    );

    modport master (
        output newdata_len, data_out, rd_en,
        input  proceed, rd_data, rd_valid, empty, level
    );
endinterface

// File: rtl/pdm_port_sink.sv
// Consumer of one PDM core port: grants packets, stores payload in a FIFO, drains oversize packets.
module pdm_port_sink #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    pdm_port_sink_if.slave   bus,
    output logic [7:0]       pkt_cnt_o,
    output logic             len_err_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    // Common width wide enough to compare a request length against DEPTH and the free space.
    localparam int unsigned CMP_W = ((LEN_W > LVL_W) ? LEN_W : LVL_W) + 1;
    localparam logic [CMP_W-1:0] DepthC = CMP_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StGrant, StRecv, StDrop} state_e;

    state_e              state_q, state_d;
    logic                drop_q, drop_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          pkt_cnt_q, pkt_cnt_d;
    logic                len_err_q, len_err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                wr_en;
    logic                rd_accept;
    logic [CMP_W-1:0]    req_len;
    logic [CMP_W-1:0]    free_space;

    assign req_len    = CMP_W'(bus.newdata_len);
    assign free_space = CMP_W'(LVL_W'(DEPTH) - level_q);
    assign rd_accept  = bus.rd_en && (level_q != '0);

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        len_err_d = len_err_q;
        wr_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_len != '0 && req_len <= free_space) begin
                    cnt_d   = bus.newdata_len;
                    drop_d  = 1'b0;
                    state_d = StGrant;
                end else if (req_len > DepthC) begin
                    cnt_d   = bus.newdata_len;
                    drop_d  = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: state_d = drop_q ? StDrop : StRecv;
            StRecv: begin
                wr_en = 1'b1;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    pkt_cnt_d = pkt_cnt_q + 8'd1;
                    state_d   = StIdle;
                end
            end
            StDrop: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    len_err_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            pkt_cnt_q  <= '0;
            len_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            len_err_q  <= len_err_d;
            rd_valid_q <= rd_accept;
            level_q    <= level_q + LVL_W'(wr_en) - LVL_W'(rd_accept);
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.data_out;
        end
    end

    assign bus.proceed  = (state_q == StGrant);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = (level_q == '0);
    assign bus.level    = level_q;
    assign pkt_cnt_o    = pkt_cnt_q;
    assign len_err_o    = len_err_q;
endmodule

// File: tb/tb_pdm_port_sink.sv
// Scoreboard bench for pdm_port_sink: directed packets, read-side monitor pops expected bytes.
module tb_pdm_port_sink;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pkt_cnt;
    logic       len_err;

    pdm_port_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    pdm_port_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .bus       (bus),
        .pkt_cnt_o (pkt_cnt),
        .len_err_o (len_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every presented read byte must match the oldest stored byte.
    always @(negedge clk) begin
        if (!reset && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_data: got unexpected byte 0x%0h, required no read data", bus.rd_data);
            end else begin
                chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_proceed(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.proceed) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL proceed_timeout: got no proceed in 40 cycles, required a grant");
        end
    endtask

    task automatic drive_bytes(input int len, input int base, input bit store, input bit rd_along);
        for (int i = 0; i < len; i++) begin
            cyc();
            bus.data_out = 8'(base + i);
            bus.rd_en    = rd_along;
            if (store) exp_q.push_back(8'(base + i));
            if (i == 0) begin
                @(negedge clk);
                chk("proceed_one_cycle", int'(bus.proceed), 0);
            end
        end
        cyc();
        bus.rd_en    = 1'b0;
        bus.data_out = '0;
    endtask

    task automatic send_pkt(input int len, input int base, input bit store, input bit rd_along);
        int lat;
        cyc();
        bus.newdata_len = LEN_W'(len);
        wait_proceed(lat);
        bus.newdata_len = '0;
        if (lat > 0) begin
            chk("proceed_latency", lat, 2);
            drive_bytes(len, base, store, rd_along);
        end
    endtask

    task automatic do_read(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            bus.rd_en = 1'b1;
        end
        cyc();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, required finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit seen;
        bus.newdata_len = '0;
        bus.data_out    = '0;
        bus.rd_en       = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_proceed", int'(bus.proceed), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_pkt_cnt", int'(pkt_cnt), 0);
        chk("rst_len_err", int'(len_err), 0);

        // Basic three-byte packet
        send_pkt(3, 'hA1, 1'b1, 1'b0);
        @(negedge clk);
        chk("basic_level", int'(bus.level), 3);
        chk("basic_pkt_cnt", int'(pkt_cnt), 1);
        chk("basic_empty", int'(bus.empty), 0);
        do_read(3);
        @(negedge clk);
        chk("basic_drained_level", int'(bus.level), 0);
        chk("basic_drained_empty", int'(bus.empty), 1);

        // Backpressure: 14 stored, len 4 must wait for two pops
        send_pkt(14, 'h10, 1'b1, 1'b0);
        cyc();
        bus.newdata_len = 8'd4;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.proceed) seen = 1'b1;
        end
        chk("bp_no_proceed", int'(seen), 0);
        cyc();
        bus.rd_en = 1'b1;
        cyc();
        cyc();
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("bp_level_12", int'(bus.level), 12);
        chk("bp_not_yet", int'(bus.proceed), 0);
        @(negedge clk);
        chk("bp_proceed", int'(bus.proceed), 1);
        bus.newdata_len = '0;
        drive_bytes(4, 'h30, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_full_level", int'(bus.level), 16);
        chk("bp_pkt_cnt", int'(pkt_cnt), 3);
        cyc();
        bus.newdata_len = 8'd1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.proceed) seen = 1'b1;
        end
        chk("full_no_proceed", int'(seen), 0);
        bus.newdata_len = '0;
        do_read(16);
        @(negedge clk);
        chk("bp_drained_level", int'(bus.level), 0);

        // Oversize packet drained and flagged
        send_pkt(20, 'h50, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_level", int'(bus.level), 0);
        chk("ovr_len_err", int'(len_err), 1);
        chk("ovr_pkt_cnt", int'(pkt_cnt), 3);
        send_pkt(2, 'h60, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovr_next_level", int'(bus.level), 2);
        chk("ovr_next_pkt_cnt", int'(pkt_cnt), 4);
        chk("ovr_sticky", int'(len_err), 1);
        do_read(2);

        // Concurrent read/write across the pointer wrap (write pointer at 14)
        send_pkt(7, 'h70, 1'b1, 1'b0);
        do_read(2);
        @(negedge clk);
        chk("conc_start_level", int'(bus.level), 5);
        send_pkt(4, 'h80, 1'b1, 1'b1);
        @(negedge clk);
        chk("conc_end_level", int'(bus.level), 5);
        chk("conc_pkt_cnt", int'(pkt_cnt), 6);
        do_read(5);
        @(negedge clk);
        chk("conc_drained", int'(bus.level), 0);

        // Reset after two of six bytes
        cyc();
        bus.newdata_len = 8'd6;
        wait_proceed(lat);
        bus.newdata_len = '0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.data_out = 8'(8'h90 + i);
        end
        cyc();
        bus.data_out = 8'h92;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.data_out = 8'h93;
        @(negedge clk);
        chk("mrst_level", int'(bus.level), 0);
        chk("mrst_proceed", int'(bus.proceed), 0);
        chk("mrst_pkt_cnt", int'(pkt_cnt), 0);
        chk("mrst_len_err", int'(len_err), 0);
        cyc();
        bus.data_out = 8'h94;
        cyc();
        bus.data_out = 8'h95;
        cyc();
        bus.data_out = '0;
        @(negedge clk);
        chk("mrst_residual_level", int'(bus.level), 0);
        send_pkt(1, 'hB0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mrst_new_level", int'(bus.level), 1);
        chk("mrst_new_pkt_cnt", int'(pkt_cnt), 1);
        do_read(1);

        // Read while empty is ignored
        cyc();
        bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("empty_rd_valid", int'(bus.rd_valid), 0);
        chk("empty_level", int'(bus.level), 0);
        chk("empty_flag", int'(bus.empty), 1);

        // Packet counter wrap
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("wrap_start", int'(pkt_cnt), 0);
        for (int k = 0; k < 256; k++) begin
            send_pkt(1, k, 1'b1, 1'b0);
            do_read(1);
            if (k == 254) chk("wrap_255", int'(pkt_cnt), 255);
        end
        @(negedge clk);
        chk("wrap_zero", int'(pkt_cnt), 0);
        chk("wrap_level", int'(bus.level), 0);

        repeat (3) cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
